// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of the single core memory bus: port 0 is instruction fetch, port 1 is load/store.
// Each port's request is latched into a pending slot, one slot is issued downstream at a time, and the response is returned to the slot's owner.
module mem_bus_arbiter #(
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        p0_request_enable,
    input  logic        p0_mode,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic        p0_response_enable,
    output logic [31:0] p0_data,

    input  logic        p1_request_enable,
    input  logic        p1_mode,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic        p1_response_enable,
    output logic [31:0] p1_data,

    output logic        m_request_enable,
    output logic        m_mode,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_response_enable,
    input  logic [31:0] m_data
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_rr_next;

    logic        r_pend0;
    logic        r_mode0;
    logic [31:0] r_addr0;
    logic [31:0] r_wdata0;
    logic [3:0]  r_wstrb0;

    logic        r_pend1;
    logic        r_mode1;
    logic [31:0] r_addr1;
    logic [31:0] r_wdata1;
    logic [3:0]  r_wstrb1;

    logic        w_done;
    logic        w_done0;
    logic        w_done1;
    logic        w_take0;
    logic        w_take1;
    logic        w_sel;

    assign w_done  = (r_state == S_WAIT) && m_response_enable;
    assign w_done0 = w_done && !r_owner;
    assign w_done1 = w_done &&  r_owner;

    // A slot being retired on this edge is free again, so the served port can be recaptured on its response edge.
    assign w_take0 = p0_request_enable && (!r_pend0 || w_done0);
    assign w_take1 = p1_request_enable && (!r_pend1 || w_done1);

    always_comb begin
        w_sel = r_pend1;
        if (r_pend0 && r_pend1) begin
            w_sel = (ROUND_ROBIN != 0) ? r_rr_next : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state            <= S_IDLE;
            r_owner            <= 1'b0;
            r_rr_next          <= 1'b0;
            r_pend0            <= 1'b0;
            r_mode0            <= 1'b0;
            r_addr0            <= '0;
            r_wdata0           <= '0;
            r_wstrb0           <= '0;
            r_pend1            <= 1'b0;
            r_mode1            <= 1'b0;
            r_addr1            <= '0;
            r_wdata1           <= '0;
            r_wstrb1           <= '0;
            p0_response_enable <= 1'b0;
            p0_data            <= '0;
            p1_response_enable <= 1'b0;
            p1_data            <= '0;
            m_request_enable   <= 1'b0;
            m_mode             <= 1'b0;
            m_addr             <= '0;
            m_wdata            <= '0;
            m_wstrb            <= '0;
        end else begin
            p0_response_enable <= 1'b0;
            p1_response_enable <= 1'b0;

            if (w_take0) begin
                r_pend0  <= 1'b1;
                r_mode0  <= p0_mode;
                r_addr0  <= p0_addr;
                r_wdata0 <= p0_wdata;
                r_wstrb0 <= p0_wstrb;
            end else if (w_done0) begin
                r_pend0  <= 1'b0;
            end

            if (w_take1) begin
                r_pend1  <= 1'b1;
                r_mode1  <= p1_mode;
                r_addr1  <= p1_addr;
                r_wdata1 <= p1_wdata;
                r_wstrb1 <= p1_wstrb;
            end else if (w_done1) begin
                r_pend1  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend0 || r_pend1) begin
                        m_request_enable <= 1'b1;
                        r_owner          <= w_sel;
                        m_mode           <= w_sel ? r_mode1  : r_mode0;
                        m_addr           <= w_sel ? r_addr1  : r_addr0;
                        m_wdata          <= w_sel ? r_wdata1 : r_wdata0;
                        m_wstrb          <= w_sel ? r_wstrb1 : r_wstrb0;
                        r_state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    m_request_enable <= 1'b0;
                    if (m_response_enable) begin
                        if (r_owner) begin
                            p1_response_enable <= 1'b1;
                            p1_data            <= m_data;
                        end else begin
                            p0_response_enable <= 1'b1;
                            p0_data            <= m_data;
                        end
                        r_rr_next <= ~r_owner;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
